uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART packetiser transmit port between two packet sources: the register Controller (requester 0) and the Streamer (requester 1). It sits between those blocks and `UART_Packets`. A grant is held from start-of-packet to end-of-packet, so the two sources' packets are never interleaved. A stall watchdog stops a stalled source from locking the link. Statistics counters are exported for the `RD_REGISTERS` map.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares the UART packetiser
// Tx port between the Controller (0) and the Streamer (1), with a stall watchdog.
package uart_tx_arbiter_pkg;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
  } UART_PACKET;
endpackage

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  UART_PACKET  ipStream0,
  output logic        opReady0,
  input  UART_PACKET  ipStream1,
  output logic        opReady1,
  output UART_PACKET  opTxStream,
  input  logic        ipTxReady,
  output logic [1:0]  opGrant,
  output logic [15:0] opPackets0,
  output logic [15:0] opPackets1,
  output logic [7:0]  opAborts,
  output logic [7:0]  opDrops
);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t         state, state_next;
  logic           last_grant, last_grant_next;
  logic [WDW-1:0] wdog;
  logic           req0, req1, drain0, drain1;
  logic           gnt_valid, gnt_eop, xfer, pkt_done, stall_out;
  logic [8:0]     drop_sum;

  assign req0      = ipStream0.Valid & ipStream0.SoP;
  assign req1      = ipStream1.Valid & ipStream1.SoP;
  assign drain0    = ipStream0.Valid & ~ipStream0.SoP;
  assign drain1    = ipStream1.Valid & ~ipStream1.SoP;
  assign gnt_valid = (state == GNT1) ? ipStream1.Valid : ipStream0.Valid;
  assign gnt_eop   = (state == GNT1) ? ipStream1.EoP : ipStream0.EoP;
  assign xfer      = (state != IDLE) & gnt_valid & ipTxReady;
  assign pkt_done  = xfer & gnt_eop;
  assign stall_out = (state != IDLE) & ~gnt_valid & (wdog == WD_LAST);
  assign drop_sum  = {1'b0, opDrops} + {8'd0, drain0} + {8'd0, drain1};

  // Next-state and output mux; drain readies are gated so reset forces them low at once.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    opReady0        = 1'b0;
    opReady1        = 1'b0;
    opTxStream      = '0;
    opGrant         = 2'b00;
    unique case (state)
      IDLE: begin
        opReady0 = drain0 & ipReset;
        opReady1 = drain1 & ipReset;
        if (req0 && req1) state_next = last_grant ? GNT0 : GNT1;
        else if (req0)    state_next = GNT0;
        else if (req1)    state_next = GNT1;
      end
      GNT0: begin
        opTxStream = ipStream0;
        opReady0   = ipTxReady;
        opGrant    = 2'b01;
        if (pkt_done || stall_out) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end
      end
      GNT1: begin
        opTxStream = ipStream1;
        opReady1   = ipTxReady;
        opGrant    = 2'b10;
        if (pkt_done || stall_out) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Back-pressured beats (Valid high, ready low) neither clear nor advance the watchdog.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset)
      wdog <= '0;
    else if (state == IDLE || xfer || stall_out)
      wdog <= '0;
    else if (!gnt_valid)
      wdog <= wdog + WDW'(1);
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opPackets0 <= '0;
      opPackets1 <= '0;
      opAborts   <= '0;
      opDrops    <= '0;
    end else begin
      if (pkt_done && state == GNT0) opPackets0 <= opPackets0 + 16'd1;
      if (pkt_done && state == GNT1) opPackets1 <= opPackets1 + 16'd1;
      if (stall_out && opAborts != 8'hFF) opAborts <= opAborts + 8'd1;
      if (state == IDLE) opDrops <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic, checked cycle by
// cycle against a packet-level reference model of the arbiter.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        resetN;
  UART_PACKET  stream0, stream1, txStream;
  logic        ready0, ready1, txReady;
  logic [1:0]  grant;
  logic [15:0] packets0, packets1;
  logic [7:0]  aborts, drops;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: owner is -1 when nobody holds the link.
  int mOwner, mLast, mLow, mPk0, mPk1, mAborts, mDrops;
  logic [1:0] eGrant;
  logic       eRdy0, eRdy1;
  UART_PACKET eTx;

  logic [7:0] delivered[$];
  int         grantLog[$];
  logic [1:0] prevGrant;

  UART_PACKET pres[2];
  bit presenting[2];
  bit inPkt[2];
  int hold[2];
  int remain[2];
  int posn[2];

  int rdyPat[18] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .ipClk      (clock),
    .ipReset    (resetN),
    .ipStream0  (stream0),
    .opReady0   (ready0),
    .ipStream1  (stream1),
    .opReady1   (ready1),
    .opTxStream (txStream),
    .ipTxReady  (txReady),
    .opGrant    (grant),
    .opPackets0 (packets0),
    .opPackets1 (packets1),
    .opAborts   (aborts),
    .opDrops    (drops)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(string tag, logic [63:0] actual, logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic UART_PACKET mkBeat(int src, bit sop, bit eop, logic [7:0] data);
    UART_PACKET b;
    b.Valid       = 1'b1;
    b.SoP         = sop;
    b.EoP         = eop;
    b.Data        = data;
    b.Source      = 8'(src);
    b.Destination = 8'(src + 1);
    b.Length      = data ^ 8'h5A;
    return b;
  endfunction

  function automatic UART_PACKET idleNoise(int src);
    UART_PACKET b;
    b = mkBeat(src, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    b.Valid = 1'b0;
    return b;
  endfunction

  task automatic modelReset();
    mOwner  = -1;
    mLast   = 1;
    mLow    = 0;
    mPk0    = 0;
    mPk1    = 0;
    mAborts = 0;
    mDrops  = 0;
  endtask

  // One clock edge of the arbiter's rules applied to the currently driven inputs.
  task automatic modelUpdate();
    UART_PACKET s;
    int d;
    bit r0, r1;
    if (mOwner < 0) begin
      d = int'(stream0.Valid && !stream0.SoP) + int'(stream1.Valid && !stream1.SoP);
      mDrops = (mDrops + d > 255) ? 255 : mDrops + d;
      r0 = stream0.Valid && stream0.SoP;
      r1 = stream1.Valid && stream1.SoP;
      if (r0 && r1) mOwner = 1 - mLast;
      else if (r0)  mOwner = 0;
      else if (r1)  mOwner = 1;
      mLow = 0;
    end else begin
      s = (mOwner == 0) ? stream0 : stream1;
      if (s.Valid && txReady) begin
        mLow = 0;
        if (s.EoP) begin
          if (mOwner == 0) mPk0 = (mPk0 + 1) % 65536;
          else             mPk1 = (mPk1 + 1) % 65536;
          mLast  = mOwner;
          mOwner = -1;
        end
      end else if (!s.Valid) begin
        mLow++;
        if (mLow == TIMEOUT) begin
          mAborts = (mAborts < 255) ? mAborts + 1 : 255;
          mLast   = mOwner;
          mOwner  = -1;
          mLow    = 0;
        end
      end
    end
  endtask

  // Runs one clock with the inputs already driven: check mid-cycle, then advance the model.
  task automatic applyStimulus();
    #3;
    eGrant = 2'b00;
    eRdy0  = 1'b0;
    eRdy1  = 1'b0;
    eTx    = '0;
    if (mOwner < 0) begin
      eRdy0 = stream0.Valid && !stream0.SoP;
      eRdy1 = stream1.Valid && !stream1.SoP;
    end else if (mOwner == 0) begin
      eGrant = 2'b01;
      eTx    = stream0;
      eRdy0  = txReady;
    end else begin
      eGrant = 2'b10;
      eTx    = stream1;
      eRdy1  = txReady;
    end
    checkOutput("grant", 64'(grant), 64'(eGrant));
    checkOutput("ready0", 64'(ready0), 64'(eRdy0));
    checkOutput("ready1", 64'(ready1), 64'(eRdy1));
    checkOutput("txStream", 64'(txStream), 64'(eTx));
    checkOutput("packets0", 64'(packets0), 64'(mPk0));
    checkOutput("packets1", 64'(packets1), 64'(mPk1));
    checkOutput("aborts", 64'(aborts), 64'(mAborts));
    checkOutput("drops", 64'(drops), 64'(mDrops));
    if (txStream.Valid && txReady) delivered.push_back(txStream.Data);
    if (grant != 2'b00 && prevGrant == 2'b00) grantLog.push_back(grant == 2'b10 ? 1 : 0);
    prevGrant = grant;
    @(posedge clock);
    modelUpdate();
    #1;
  endtask

  task automatic applyReset();
    resetN  = 1'b0;
    stream0 = '0;
    stream1 = '0;
    txReady = 1'b0;
    modelReset();
    prevGrant = 2'b00;
    @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  task automatic genBeats();
    int r;
    for (int i = 0; i < 2; i++) begin
      if (!presenting[i]) begin
        if (hold[i] > 0) begin
          hold[i]--;
        end else begin
          r = $urandom_range(0, 99);
          if (remain[i] > 0) begin
            if (r < 10) hold[i] = $urandom_range(1, 12);
            else begin
              pres[i] = mkBeat(i, posn[i] == 0, remain[i] == 1, 8'($urandom));
              presenting[i] = 1'b1;
              inPkt[i] = 1'b1;
            end
          end else if (r < 30) begin
            remain[i] = $urandom_range(1, 5);
            posn[i] = 0;
            pres[i] = mkBeat(i, 1'b1, remain[i] == 1, 8'($urandom));
            presenting[i] = 1'b1;
            inPkt[i] = 1'b1;
          end else if (r < 36) begin
            pres[i] = mkBeat(i, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            presenting[i] = 1'b1;
            inPkt[i] = 1'b0;
          end
        end
      end
    end
    stream0 = presenting[0] ? pres[0] : idleNoise(0);
    stream1 = presenting[1] ? pres[1] : idleNoise(1);
    txReady = ($urandom_range(0, 99) < 75);
  endtask

  task automatic advanceSources();
    bit acc;
    for (int i = 0; i < 2; i++) begin
      acc = (i == 0) ? eRdy0 : eRdy1;
      if (presenting[i] && acc) begin
        presenting[i] = 1'b0;
        if (inPkt[i]) begin
          remain[i]--;
          posn[i]++;
        end
      end
    end
  endtask

  initial begin
    UART_PACKET b[5];
    int idx[2];
    int bi;

    // Reset state, with drain-style beats present to show readies stay low.
    resetN  = 1'b0;
    stream0 = mkBeat(0, 1'b0, 1'b0, 8'h01);
    stream1 = mkBeat(1, 1'b0, 1'b0, 8'h02);
    txReady = 1'b1;
    modelReset();
    prevGrant = 2'b00;
    #2;
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_ready0", 64'(ready0), 64'd0);
    checkOutput("rst_ready1", 64'(ready1), 64'd0);
    checkOutput("rst_tx", 64'(txStream), 64'd0);
    checkOutput("rst_pk0", 64'(packets0), 64'd0);
    checkOutput("rst_pk1", 64'(packets1), 64'd0);
    checkOutput("rst_aborts", 64'(aborts), 64'd0);
    checkOutput("rst_drops", 64'(drops), 64'd0);
    applyReset();

    // Single source: four-beat packet 0x11..0x14.
    delivered.delete();
    for (int k = 0; k < 4; k++) b[k] = mkBeat(0, k == 0, k == 3, 8'h11 + 8'(k));
    txReady = 1'b1;
    stream0 = b[0];
    applyStimulus();
    checkOutput("single_grant", 64'(grant), 64'd1);
    for (int k = 0; k < 4; k++) begin
      stream0 = b[k];
      applyStimulus();
    end
    stream0 = '0;
    applyStimulus();
    checkOutput("single_idle", 64'(grant), 64'd0);
    checkOutput("single_pk0", 64'(packets0), 64'd1);
    checkOutput("single_count", 64'(delivered.size()), 64'd4);
    for (int k = 0; k < 4 && k < delivered.size(); k++)
      checkOutput($sformatf("single_data%0d", k), 64'(delivered[k]), 64'(8'h11 + 8'(k)));

    // Fairness: both sources keep offering two-beat packets.
    applyReset();
    grantLog.delete();
    idx[0] = 0;
    idx[1] = 0;
    txReady = 1'b1;
    for (int cyc = 0; cyc < 100 && (mPk0 + mPk1) < 6; cyc++) begin
      stream0 = mkBeat(0, idx[0] == 0, idx[0] == 1, 8'hA0 + 8'(idx[0]));
      stream1 = mkBeat(1, idx[1] == 0, idx[1] == 1, 8'hB0 + 8'(idx[1]));
      applyStimulus();
      if (eRdy0) idx[0] ^= 1;
      if (eRdy1) idx[1] ^= 1;
    end
    stream0 = '0;
    stream1 = '0;
    applyStimulus();
    checkOutput("fair_pk0", 64'(packets0), 64'd3);
    checkOutput("fair_pk1", 64'(packets1), 64'd3);
    checkOutput("fair_grants", 64'(grantLog.size()), 64'd6);
    for (int k = 0; k < 6 && k < grantLog.size(); k++)
      checkOutput($sformatf("fair_order%0d", k), 64'(grantLog[k]), 64'(k % 2));

    // Back-pressure longer than the watchdog limit must not abort.
    delivered.delete();
    bi = 0;
    for (int k = 0; k < 18; k++) begin
      stream0 = (bi < 3) ? mkBeat(0, bi == 0, bi == 2, 8'h21 + 8'(bi)) : '0;
      txReady = rdyPat[k][0];
      applyStimulus();
      if (eRdy0 && stream0.Valid) bi++;
    end
    stream0 = '0;
    txReady = 1'b1;
    applyStimulus();
    checkOutput("bp_count", 64'(delivered.size()), 64'd3);
    for (int k = 0; k < 3 && k < delivered.size(); k++)
      checkOutput($sformatf("bp_data%0d", k), 64'(delivered[k]), 64'(8'h21 + 8'(k)));
    checkOutput("bp_aborts", 64'(aborts), 64'd0);
    checkOutput("bp_pk0", 64'(packets0), 64'd4);

    // Watchdog: requester 1 stalls mid-packet while requester 0 waits.
    stream1 = mkBeat(1, 1'b1, 1'b0, 8'h31);
    applyStimulus();
    checkOutput("wd_grant1", 64'(grant), 64'd2);
    stream0 = mkBeat(0, 1'b1, 1'b1, 8'h41);
    applyStimulus();
    stream1 = '0;
    for (int k = 0; k < TIMEOUT; k++) begin
      checkOutput($sformatf("wd_hold%0d", k), 64'(grant), 64'd2);
      applyStimulus();
    end
    checkOutput("wd_revoked", 64'(grant), 64'd0);
    checkOutput("wd_aborts", 64'(aborts), 64'd1);
    applyStimulus();
    checkOutput("wd_next", 64'(grant), 64'd1);
    applyStimulus();
    stream0 = '0;
    applyStimulus();

    // Drain: 300 beats without SoP in IDLE.
    delivered.delete();
    for (int k = 0; k < 300; k++) begin
      stream0 = mkBeat(0, 1'b0, (k % 7) == 0, 8'(k));
      applyStimulus();
    end
    stream0 = '0;
    applyStimulus();
    checkOutput("drain_sat", 64'(drops), 64'hFF);
    checkOutput("drain_fwd", 64'(delivered.size()), 64'd0);

    // Reset asserted after beat 2 of a five-beat packet.
    for (int k = 0; k < 5; k++) b[k] = mkBeat(0, k == 0, k == 4, 8'h61 + 8'(k));
    stream0 = b[0];
    applyStimulus();
    applyStimulus();
    stream0 = b[1];
    applyStimulus();
    stream0 = b[2];
    stream1 = mkBeat(1, 1'b0, 1'b0, 8'h77);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("mid_grant", 64'(grant), 64'd0);
    checkOutput("mid_ready0", 64'(ready0), 64'd0);
    checkOutput("mid_ready1", 64'(ready1), 64'd0);
    checkOutput("mid_tx", 64'(txStream), 64'd0);
    checkOutput("mid_pk0", 64'(packets0), 64'd0);
    checkOutput("mid_pk1", 64'(packets1), 64'd0);
    checkOutput("mid_aborts", 64'(aborts), 64'd0);
    checkOutput("mid_drops", 64'(drops), 64'd0);
    modelReset();
    prevGrant = 2'b00;
    stream0 = mkBeat(0, 1'b1, 1'b0, 8'h51);
    stream1 = mkBeat(1, 1'b1, 1'b0, 8'h52);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    applyStimulus();
    checkOutput("mid_tie", 64'(grant), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2; i++) begin
      presenting[i] = 1'b0;
      inPkt[i] = 1'b0;
      hold[i] = 0;
      remain[i] = 0;
      posn[i] = 0;
    end
    for (int cyc = 0; cyc < 2500; cyc++) begin
      genBeats();
      applyStimulus();
      advanceSources();
    end
    stream0 = '0;
    stream1 = '0;
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
